sram_arbiter: RTL

- Two-port arbiter and sequencer in front of the 32-bit SRAM_top word memory. SRAM_top is a 16-bit SRAM accessed in two beats, with an active-low CS.
- Lets two requesters (port 0 = instruction fetch, port 1 = data memory) share that memory.
- Latches one request, holds the SRAM_top address, control and data stable for a fixed number of cycles, captures read data, and returns a one-cycle ack.
- Deasserts CS between accesses so SRAM_top's internal sequencer restarts.

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/rr_arbiter2.sv | 23 ++
 rtl/sram_arbiter.sv | 137 +++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter.
// Imported by the arbiter top and its round-robin picker.
package sram_arb_pkg;

    localparam int DEF_ADDR_W = 11;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        RECOVER = 2'd2
    } state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: on a tie the port that did not win last
// time is chosen. Purely combinational.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    always_comb begin
        grant_valid = req0 | req1;
        grant_id    = PORT0;
        unique case ({req1, req0})
            2'b11:   grant_id = ~last_grant;
            2'b10:   grant_id = PORT1;
            default: grant_id = PORT0;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto the SRAM_top word memory, holding the
// address/control/data stable for a fixed access window, then recovering.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_CYCLES = 4,
    parameter int WR_CYCLES = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              ack0,
    output logic              ack1,
    output logic              busy,
    inout  wire  [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_cs_n,
    output logic              mem_write
);

    localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;

    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              lat_port;
    logic              lat_we;
    logic [DATA_W-1:0] lat_wdata;
    logic              drive;

    logic              grant_valid;
    logic              grant_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    rr_arbiter2 u_rr (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    always_comb begin
        sel_we    = we0;
        sel_addr  = addr0;
        sel_wdata = wdata0;
        if (grant_id == PORT1) begin
            sel_we    = we1;
            sel_addr  = addr1;
            sel_wdata = wdata1;
        end
    end

    // Only a write in progress owns the bus; reads and idle leave it floating.
    assign mem_data = drive ? lat_wdata : {DATA_W{1'bz}};

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= PORT1;
            lat_port   <= PORT0;
            lat_we     <= 1'b0;
            lat_wdata  <= '0;
            drive      <= 1'b0;
            mem_cs_n   <= 1'b1;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    ack0 <= 1'b0;
                    ack1 <= 1'b0;
                    if (grant_valid) begin
                        lat_port   <= grant_id;
                        lat_we     <= sel_we;
                        lat_wdata  <= sel_wdata;
                        last_grant <= grant_id;
                        cnt        <= sel_we ? WR_LOAD : RD_LOAD;
                        mem_addr   <= sel_addr;
                        mem_write  <= sel_we;
                        drive      <= sel_we;
                        mem_cs_n   <= 1'b0;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        if (!lat_we) begin
                            if (lat_port == PORT1) rdata1 <= mem_data;
                            else                   rdata0 <= mem_data;
                        end
                        mem_cs_n  <= 1'b1;
                        mem_write <= 1'b0;
                        drive     <= 1'b0;
                        ack0      <= (lat_port == PORT0);
                        ack1      <= (lat_port == PORT1);
                        state     <= RECOVER;
                    end
                end
                RECOVER: begin
                    ack0  <= 1'b0;
                    ack1  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
